crack_collect: RTL and testbench
================================

CRACK_COLLECT -- requirements
Module: crack_collect

Interface
REQ-001 clk  input  1  single system clock; all state advances on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 en  input  1  start request; accepted only while rdy=1.
REQ-004 rdy  output  1  high when idle or done and able to accept en.
REQ-005 c0_en, c1_en  output  1 each  one-cycle launch pulse to crack core 0 (even keys) and core 1 (odd keys).
REQ-006 c0_rdy, c1_rdy  input  1 each  core idle/finished flag; high again after launch means that core has finished.
REQ-007 c0_key_valid, c1_key_valid  input  1 each  core found a key; sampled only when the matching cN_rdy rises.
REQ-008 c0_key, c1_key  input  24 each  candidate key from each core; sampled with its valid.
REQ-009 stop  output  1  one-cycle abort pulse to both cores.
REQ-010 key  output  24  winning key.
REQ-011 key_valid  output  1  key holds a found key.
REQ-012 done  output  1  search finished; held until next accepted en.
REQ-013 cycles  output  32  clock cycles from launch to done, saturating.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT, ABORT, DRAIN, DONE.
REQ-015 IDLE: rdy=1; en=1 -> LAUNCH, clear key, key_valid, done, cycles.
REQ-016 LAUNCH: c0_en=c1_en=1 for exactly one cycle -> WAIT; en in LAUNCH/WAIT/ABORT/DRAIN ignored.
REQ-017 WAIT: ignore cN_rdy in the first cycle after LAUNCH (cores drop rdy one cycle late); afterwards a 0->1 edge on cN_rdy marks core N finished.
REQ-018 In WAIT, the first finished core with key_valid=1 wins: latch its key, key_valid=1 -> ABORT.
REQ-019 Same-cycle finish with both valid: lower numeric key wins; tie: core 0 wins.
REQ-020 Both cores finished with key_valid=0 -> DONE with key_valid=0 and key=24'h000000.
REQ-021 One core finished invalid: record it and keep waiting for the other.
REQ-022 ABORT: stop=1 for one cycle -> DRAIN.
REQ-023 DRAIN: wait until c0_rdy=1 and c1_rdy=1 -> DONE; results reported during DRAIN are ignored.
REQ-024 DONE: done=1, rdy=1, key and key_valid held; en=1 -> LAUNCH with same clears as IDLE.
REQ-025 cycles: counts +1 per cycle from LAUNCH through DRAIN inclusive; frozen in DONE.
REQ-026 cycles saturates at 32'hFFFFFFFF and never wraps.
REQ-027 Output latency: key, key_valid, and done are registered.
REQ-028 done rises exactly one cycle after the DRAIN/WAIT exit condition is seen.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 rst_n=0 asynchronously forces:
- state=IDLE, rdy=1, done=0, key_valid=0, key=0, cycles=0;
- c0_en=c1_en=stop=0.
REQ-031 Reset asserted mid-search (any state) aborts without a stop pulse.
REQ-032 After reset release, the first accepted en starts a clean search.

Verification
REQ-033 Core1 finishes at cycle 40 with valid, key 24'h00A3C1 -> stop pulse, then done=1 after both rdy, key=00A3C1, key_valid=1, cycles≈ launch-to-done count.
REQ-034 Both cores finish in the same cycle, both valid, c0_key=24'h000102, c1_key=24'h000101 -> key=000101.
REQ-035 Core0 finishes invalid at cycle 20; core1 finishes invalid at cycle 50 -> done=1, key_valid=0, key=0, no stop pulse.
REQ-036 en pulsed during WAIT -> ignored, no second c0_en/c1_en pulse; en in DONE -> relaunch with cleared outputs.
REQ-037 rst_n dropped during WAIT -> all outputs at reset values immediately, with no clock edge required.
REQ-038 Forced cycle counter near 32'hFFFFFFFE, run 5 more cycles -> cycles=32'hFFFFFFFF.

Source files
------------

// File: rtl/crack_collect.sv
// crack_collect: launches two key-search cores (even/odd key halves), waits for
// the first valid result, aborts the other core, drains both and reports the
// winning key together with a saturating launch-to-done cycle count.
module crack_collect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        c0_en,
  output logic        c1_en,
  input  logic        c0_rdy,
  input  logic        c1_rdy,
  input  logic        c0_key_valid,
  input  logic        c1_key_valid,
  input  logic [23:0] c0_key,
  input  logic [23:0] c1_key,
  output logic        stop,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        done,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ABORT  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t      state_r, state_s;

  // first_r marks the first WAIT cycle, when core rdy flags are still stale
  logic        first_r;
  logic        c0_rdy_d_r, c1_rdy_d_r;
  logic        c0_fin_r, c1_fin_r, c0_fin_s, c1_fin_s;

  logic        rdy_r, c0_en_r, c1_en_r, stop_r, key_valid_r, done_r;
  logic [23:0] key_r;
  logic [31:0] cycles_r;

  logic        rdy_s, cen_s, stop_s, key_valid_s, done_s;
  logic [23:0] key_s;
  logic [31:0] cycles_s;

  logic        c0_rise_s, c1_rise_s, c0_hit_s, c1_hit_s;
  logic        c0_done_s, c1_done_s, win_s, pick1_s, accept_s, busy_s;
  logic [23:0] win_key_s;

  // Finish detection and winner selection (lower key wins a same-cycle tie-break, core 0 on equal keys)
  always_comb begin
    c0_rise_s = c0_rdy & ~c0_rdy_d_r & ~first_r;
    c1_rise_s = c1_rdy & ~c1_rdy_d_r & ~first_r;
    c0_hit_s  = c0_rise_s & c0_key_valid & ~c0_fin_r;
    c1_hit_s  = c1_rise_s & c1_key_valid & ~c1_fin_r;
    c0_done_s = c0_fin_r | c0_rise_s;
    c1_done_s = c1_fin_r | c1_rise_s;
    win_s     = c0_hit_s | c1_hit_s;
    if (c0_hit_s && c1_hit_s) begin
      pick1_s = (c1_key < c0_key);
    end else begin
      pick1_s = c1_hit_s;
    end
    win_key_s = pick1_s ? c1_key : c0_key;
    accept_s  = en & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    busy_s    = (state_r == ST_LAUNCH) | (state_r == ST_WAIT) |
                (state_r == ST_ABORT)  | (state_r == ST_DRAIN);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (en) state_s = ST_LAUNCH; else state_s = ST_IDLE;
      ST_LAUNCH: state_s = ST_WAIT;
      ST_WAIT: begin
        if (win_s) begin
          state_s = ST_ABORT;
        end else if (c0_done_s && c1_done_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ABORT:  state_s = ST_DRAIN;
      ST_DRAIN:  if (c0_rdy && c1_rdy) state_s = ST_DONE; else state_s = ST_DRAIN;
      ST_DONE:   if (en) state_s = ST_LAUNCH; else state_s = ST_DONE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and bookkeeping
  always_comb begin
    rdy_s       = (state_s == ST_IDLE) | (state_s == ST_DONE);
    cen_s       = (state_s == ST_LAUNCH);
    stop_s      = (state_s == ST_ABORT);
    done_s      = (state_s == ST_DONE);
    key_s       = key_r;
    key_valid_s = key_valid_r;
    c0_fin_s    = c0_fin_r;
    c1_fin_s    = c1_fin_r;
    if (accept_s) begin
      key_s       = 24'h000000;
      key_valid_s = 1'b0;
      c0_fin_s    = 1'b0;
      c1_fin_s    = 1'b0;
    end else if (state_r == ST_WAIT) begin
      c0_fin_s = c0_done_s;
      c1_fin_s = c1_done_s;
      if (win_s) begin
        key_s       = win_key_s;
        key_valid_s = 1'b1;
      end else begin
        key_s       = key_r;
        key_valid_s = key_valid_r;
      end
    end else begin
      key_s       = key_r;
      key_valid_s = key_valid_r;
    end
    if (accept_s) begin
      cycles_s = 32'd0;
    end else if (busy_s && (cycles_r != 32'hFFFF_FFFF)) begin
      cycles_s = cycles_r + 32'd1;
    end else begin
      cycles_s = cycles_r;
    end
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r       <= 1'b1;
      c0_en_r     <= 1'b0;
      c1_en_r     <= 1'b0;
      stop_r      <= 1'b0;
      done_r      <= 1'b0;
      key_r       <= 24'h000000;
      key_valid_r <= 1'b0;
      cycles_r    <= 32'd0;
      first_r     <= 1'b0;
      c0_rdy_d_r  <= 1'b1;
      c1_rdy_d_r  <= 1'b1;
      c0_fin_r    <= 1'b0;
      c1_fin_r    <= 1'b0;
    end else begin
      rdy_r       <= rdy_s;
      c0_en_r     <= cen_s;
      c1_en_r     <= cen_s;
      stop_r      <= stop_s;
      done_r      <= done_s;
      key_r       <= key_s;
      key_valid_r <= key_valid_s;
      cycles_r    <= cycles_s;
      first_r     <= (state_r == ST_LAUNCH);
      c0_rdy_d_r  <= c0_rdy;
      c1_rdy_d_r  <= c1_rdy;
      c0_fin_r    <= c0_fin_s;
      c1_fin_r    <= c1_fin_s;
    end
  end

  assign rdy       = rdy_r;
  assign c0_en     = c0_en_r;
  assign c1_en     = c1_en_r;
  assign stop      = stop_r;
  assign done      = done_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign cycles    = cycles_r;

endmodule

// File: tb/tb_crack_collect.sv
// Bench for crack_collect: two behavioural crack cores, a scoreboard of
// expected search results, and a checking task for every comparison.
module tb_crack_collect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy, c0_en, c1_en, stop, key_valid, done;
  logic [23:0] key;
  logic [31:0] cycles;

  logic        c_rdy [2];
  logic        c_kv  [2];
  logic [23:0] c_k   [2];

  // core model configuration (written by the run task, read by the model)
  int          m_lat [2];
  bit          m_vld [2];
  logic [23:0] m_key [2];

  int n_cen0 = 0, n_cen1 = 0, n_stop = 0, n_busy = 0;
  int n_vec = 0, n_err = 0;

  typedef struct {
    logic        kv;
    logic [23:0] k;
    int          stops;
    bit          sat;
  } exp_t;
  exp_t sb[$];

  crack_collect dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .c0_en(c0_en), .c1_en(c1_en),
    .c0_rdy(c_rdy[0]), .c1_rdy(c_rdy[1]),
    .c0_key_valid(c_kv[0]), .c1_key_valid(c_kv[1]),
    .c0_key(c_k[0]), .c1_key(c_k[1]),
    .stop(stop), .key(key), .key_valid(key_valid), .done(done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Behavioural cores plus pulse/busy monitors, all evaluated on the falling edge
  initial begin
    int  cnt [2];
    bit  act [2];
    bit  abrt[2];
    bit  go;
    for (int i = 0; i < 2; i++) begin
      c_rdy[i] = 1'b1; c_kv[i] = 1'b0; c_k[i] = 24'h0;
      act[i] = 1'b0; abrt[i] = 1'b0; cnt[i] = 0;
      m_lat[i] = 10; m_vld[i] = 1'b0; m_key[i] = 24'h0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          act[i] = 1'b0; c_rdy[i] = 1'b1; c_kv[i] = 1'b0;
        end
      end else begin
        if (c0_en) n_cen0++;
        if (c1_en) n_cen1++;
        if (stop)  n_stop++;
        if (!rdy)  n_busy++;
        for (int i = 0; i < 2; i++) begin
          go = (i == 0) ? c0_en : c1_en;
          if (go) begin
            act[i] = 1'b1; cnt[i] = m_lat[i]; abrt[i] = 1'b0; c_kv[i] = 1'b0;
          end else if (act[i]) begin
            c_rdy[i] = 1'b0;
            if (stop) begin
              abrt[i] = 1'b1;
              if (cnt[i] > 3) cnt[i] = 3;
            end
            cnt[i]--;
            if (cnt[i] <= 0) begin
              c_rdy[i] = 1'b1;
              c_kv[i]  = m_vld[i] & ~abrt[i];
              c_k[i]   = abrt[i] ? 24'hDEAD00 : m_key[i];
              act[i]   = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic launch();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic run_search(input int l0, input bit v0, input logic [23:0] k0,
                            input int l1, input bit v1, input logic [23:0] k1,
                            input bit poke_en, input bit sat);
    exp_t e;
    int   cen0_s, cen1_s, stop_s, busy_s, n;
    e.sat = sat;
    if (v0 && v1) begin
      if (l0 < l1)      e.k = k0;
      else if (l1 < l0) e.k = k1;
      else              e.k = (k1 < k0) ? k1 : k0;
    end else if (v0) begin
      e.k = k0;
    end else if (v1) begin
      e.k = k1;
    end else begin
      e.k = 24'h0;
    end
    e.kv    = v0 | v1;
    e.stops = (v0 | v1) ? 1 : 0;
    sb.push_back(e);
    m_lat[0] = l0; m_vld[0] = v0; m_key[0] = k0;
    m_lat[1] = l1; m_vld[1] = v1; m_key[1] = k1;
    cen0_s = n_cen0; cen1_s = n_cen1; stop_s = n_stop; busy_s = n_busy;
    launch();
    // DUT is in LAUNCH now: previous results must be cleared
    chk("launch_key",    {8'd0, key},         32'd0);
    chk("launch_kv",     {31'd0, key_valid},  32'd0);
    chk("launch_done",   {31'd0, done},       32'd0);
    chk("launch_cycles", cycles,              32'd0);
    chk("launch_rdy",    {31'd0, rdy},        32'd0);
    if (poke_en) begin
      repeat (4) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
    end
    if (sat) begin
      repeat (2) @(negedge clk);
      force dut.cycles_r = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.cycles_r;
    end
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      chk("key",       {8'd0, key},        {8'd0, e.k});
      chk("key_valid", {31'd0, key_valid}, {31'd0, e.kv});
      chk("rdy_done",  {31'd0, rdy},       32'd1);
      chk("stops",     32'(n_stop - stop_s), 32'(e.stops));
      chk("c0_en_cnt", 32'(n_cen0 - cen0_s), 32'd1);
      chk("c1_en_cnt", 32'(n_cen1 - cen1_s), 32'd1);
      if (e.sat) chk("cycles_sat", cycles, 32'hFFFF_FFFF);
      else       chk("cycles",     cycles, 32'(n_busy - busy_s));
      // done and results hold while idle in DONE
      repeat (3) @(negedge clk);
      chk("done_hold", {31'd0, done},      32'd1);
      chk("key_hold",  {8'd0, key},        {8'd0, e.k});
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rdy"},    {31'd0, rdy},       32'd1);
    chk({pfx, "_done"},   {31'd0, done},      32'd0);
    chk({pfx, "_kv"},     {31'd0, key_valid}, 32'd0);
    chk({pfx, "_key"},    {8'd0, key},        32'd0);
    chk({pfx, "_cycles"}, cycles,             32'd0);
    chk({pfx, "_en"},     {30'd0, c0_en, c1_en}, 32'd0);
    chk({pfx, "_stop"},   {31'd0, stop},      32'd0);
  endtask

  initial begin
    int stop_s;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_search(100, 1'b0, 24'h0,      40, 1'b1, 24'h00A3C1, 1'b0, 1'b0);
    run_search(15,  1'b1, 24'h000102, 15, 1'b1, 24'h000101, 1'b0, 1'b0);
    run_search(15,  1'b1, 24'h5A5A5A, 15, 1'b1, 24'h5A5A5A, 1'b0, 1'b0);
    run_search(12,  1'b1, 24'h000010, 12, 1'b1, 24'h000020, 1'b0, 1'b0);
    run_search(20,  1'b0, 24'h0,      50, 1'b0, 24'h0,      1'b0, 1'b0);
    run_search(10,  1'b1, 24'h800000, 12, 1'b1, 24'h000001, 1'b1, 1'b0);
    run_search(8,   1'b0, 24'h0,      30, 1'b1, 24'h00BEEF, 1'b0, 1'b0);

    // reset dropped mid-WAIT: outputs return to reset values without a clock edge
    m_lat[0] = 60; m_vld[0] = 1'b1; m_key[0] = 24'h111111;
    m_lat[1] = 60; m_vld[1] = 1'b1; m_key[1] = 24'h222222;
    stop_s = n_stop;
    launch();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_nostop", 32'(n_stop - stop_s), 32'd0);

    run_search(9,  1'b1, 24'h123456, 9,  1'b0, 24'h0,      1'b0, 1'b0);
    run_search(30, 1'b0, 24'h0,      25, 1'b1, 24'h000042, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
